block_motion_sched: RTL and testbench
=====================================

BLOCK_MOTION_SCHED -- requirements
Module: block_motion_sched

Interface
REQ-001 Parameter H_DISP, default 11'd1280, active pixels per line.
REQ-002 Parameter V_DISP, default 11'd720, active lines per frame.
REQ-003 Parameter SIDE_W, default 11'd40, screen border width in pixels.
REQ-004 Parameter BLOCK_W, default 11'd40, square object edge in pixels.
REQ-005 pixel_clk  in  1  sole clock; all logic SHALL be clocked on its rising edge.
REQ-006 sys_rst_n  in  1  reset; asynchronous assert, active-low.
REQ-007 frame_start  in  1  one-cycle pulse at start of vertical blanking.
REQ-008 cfg_we  in  1  config write strobe.
REQ-009 cfg_addr  in  2  object index 0..3.
REQ-010 cfg_wdata  in  9  bit8 enable, bits7:4 vertical speed, bits3:0 horizontal speed (px/frame).
REQ-011 obj_x  out  44  four 11-bit top-left X coordinates, obj0 in bits10:0.
REQ-012 obj_y  out  44  four 11-bit top-left Y coordinates, same packing.
REQ-013 obj_valid  out  4  per-object enable.
REQ-014 busy  out  1  high while an update sweep is in progress.
REQ-015 update_done  out  1  one-cycle pulse when a sweep completes.
REQ-016 overrun  out  1  one-cycle pulse when frame_start arrives while busy.

Function
REQ-017 Limits SHALL be XMIN=SIDE_W, XMAX=H_DISP-SIDE_W-BLOCK_W (1200), YMIN=SIDE_W, YMAX=V_DISP-SIDE_W-BLOCK_W (640).
REQ-018 FSM states SHALL be IDLE, UPD, DONE; IDLE->UPD on frame_start, UPD->DONE after idx 3, DONE->IDLE unconditionally.
REQ-019 On the edge sampling frame_start in IDLE, state SHALL become UPD with idx=0 and busy=1.
REQ-020 Each UPD cycle SHALL update object idx at the next edge, then increment idx; obj3 is written on the 4th edge after frame_start sampling.
REQ-021 In DONE, update_done SHALL be 1 for exactly one cycle; busy SHALL drop on entry to IDLE.
REQ-022 Disabled objects SHALL be skipped in place (one UPD cycle, no change).
REQ-023 Step arithmetic SHALL use 12 bits; moving positive: if pos+spd>=MAX then pos=MAX and dir flips negative, else pos+=spd.
REQ-024 Moving negative: if pos<=MIN+spd then pos=MIN and dir flips positive, else pos-=spd.
REQ-025 Speed 0 SHALL leave position and direction unchanged, even at a limit.
REQ-026 frame_start while busy SHALL be ignored and SHALL pulse overrun the next cycle.
REQ-027 cfg writes SHALL be accepted in any state; a write to the object being updated that same cycle SHALL take effect from the next frame.
REQ-028 Enabling an object SHALL NOT alter its stored position or direction.

Reset
REQ-029 On reset: obj i x=SIDE_W+80*i (40,120,200,280), y=40, directions positive, speeds 1/1, obj_valid=4'b0001.
REQ-030 On reset: state IDLE, idx 0, busy=0, update_done=0, overrun=0; reset mid-sweep SHALL abandon the sweep.

Configuration
REQ-031 With MOTION_PAUSE_EN defined, an input port pause (1 bit) SHALL exist; while pause=1, frame_start SHALL be ignored in IDLE, without overrun or update_done.
REQ-032 Without MOTION_PAUSE_EN, the pause port SHALL be absent and behaviour SHALL equal pause=0.

Structure
REQ-033 A shared package motion_pkg SHALL hold the FSM state type, NUM_OBJ=4, and the default limit constants.
REQ-034 Sub-module axis_step SHALL implement REQ-023..025 combinationally for one axis (pos, dir, spd, min, max -> pos, dir); two instances SHALL be shared across objects via idx.

Verification
REQ-035 Reset, one frame_start -> obj0 = (41,41) 4 edges later; obj1..3 unchanged; update_done one cycle, busy 5 cycles.
REQ-036 cfg obj0 = 9'h10F (h15, v0, enabled), 78 frames -> x=1200 with h-dir negative, y=40; frame 79 -> x=1185.
REQ-037 frame_start pulsed 2 cycles after a prior frame_start -> overrun pulse, one sweep only, one update_done.
REQ-038 cfg write to obj2 with 9'h111, then frame_start -> obj2 = (201,41), obj_valid=4'b0101.
REQ-039 Assert sys_rst_n low during UPD idx 2 -> all outputs return to REQ-029/030 values immediately; no update_done.
REQ-040 With MOTION_PAUSE_EN, pause=1 and 3 frame_start pulses -> positions unchanged, no update_done, no overrun.

Source files
------------

// File: rtl/block_motion_sched_pkg.sv
// motion_pkg: shared types and constants for the block motion scheduler.
//   state_t      - sweep FSM state encoding
//   NUM_OBJ      - number of moving objects
//   *_DEF        - default display geometry and derived motion limits
//   init_x()     - power-on X coordinate of object i
package motion_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UPD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int NUM_OBJ = 4;

  localparam logic [10:0] H_DISP_DEF  = 11'd1280;
  localparam logic [10:0] V_DISP_DEF  = 11'd720;
  localparam logic [10:0] SIDE_W_DEF  = 11'd40;
  localparam logic [10:0] BLOCK_W_DEF = 11'd40;

  localparam logic [10:0] XMIN_DEF = SIDE_W_DEF;
  localparam logic [10:0] XMAX_DEF = H_DISP_DEF - SIDE_W_DEF - BLOCK_W_DEF;
  localparam logic [10:0] YMIN_DEF = SIDE_W_DEF;
  localparam logic [10:0] YMAX_DEF = V_DISP_DEF - SIDE_W_DEF - BLOCK_W_DEF;

  // Objects start spaced 80 px apart along the top-left border.
  function automatic logic [10:0] init_x(input logic [10:0] side_w, input int i);
    return side_w + 11'(80 * i);
  endfunction

endpackage

// File: rtl/block_motion_sched_axis_step.sv
// axis_step: one-axis bounce step, purely combinational.
//   pos, dir_neg, spd      - current coordinate, direction (1 = moving negative), speed
//   pos_min, pos_max       - travel limits
//   pos_next, dir_neg_next - coordinate/direction after one frame
module axis_step (
  input  logic [10:0] pos,
  input  logic        dir_neg,
  input  logic [3:0]  spd,
  input  logic [10:0] pos_min,
  input  logic [10:0] pos_max,
  output logic [10:0] pos_next,
  output logic        dir_neg_next
);

  logic [11:0] sum_up;
  logic [11:0] low_thresh;

  // 12-bit sums so pos+spd near the 11-bit ceiling cannot wrap.
  assign sum_up     = {1'b0, pos} + {8'b0, spd};
  assign low_thresh = {1'b0, pos_min} + {8'b0, spd};

  always_comb begin
    pos_next     = pos;
    dir_neg_next = dir_neg;
    // A stopped object holds even when parked on a limit.
    if (spd != 4'd0) begin
      if (!dir_neg) begin
        if (sum_up >= {1'b0, pos_max}) begin
          pos_next     = pos_max;
          dir_neg_next = 1'b1;
        end else begin
          pos_next = sum_up[10:0];
        end
      end else begin
        if ({1'b0, pos} <= low_thresh) begin
          pos_next     = pos_min;
          dir_neg_next = 1'b0;
        end else begin
          pos_next = pos - {7'b0, spd};
        end
      end
    end
  end

endmodule

// File: rtl/block_motion_sched.sv
// block_motion_sched: once per frame, sweeps four bouncing square objects and
// steps each enabled one by its per-axis speed inside the screen border.
//   pixel_clk, sys_rst_n       - clock, async active-low reset
//   frame_start                - sweep trigger (start of vertical blanking)
//   cfg_we/cfg_addr/cfg_wdata  - per-object {enable, v speed, h speed}
//   pause (MOTION_PAUSE_EN)    - suppresses new sweeps while high
//   obj_x, obj_y, obj_valid    - packed positions (obj0 in LSBs), enables
//   busy, update_done, overrun - sweep status
// Optional feature macro: MOTION_PAUSE_EN adds the pause input.
//
// state   | meaning
// IDLE    | waiting for frame_start
// UPD     | stepping object idx, one object per cycle
// DONE    | sweep finished, update_done pulse
module block_motion_sched
  import motion_pkg::*;
#(
  parameter logic [10:0] H_DISP  = H_DISP_DEF,
  parameter logic [10:0] V_DISP  = V_DISP_DEF,
  parameter logic [10:0] SIDE_W  = SIDE_W_DEF,
  parameter logic [10:0] BLOCK_W = BLOCK_W_DEF
) (
  input  logic        pixel_clk,
  input  logic        sys_rst_n,
  input  logic        frame_start,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_addr,
  input  logic [8:0]  cfg_wdata,
`ifdef MOTION_PAUSE_EN
  input  logic        pause,
`endif
  output logic [43:0] obj_x,
  output logic [43:0] obj_y,
  output logic [3:0]  obj_valid,
  output logic        busy,
  output logic        update_done,
  output logic        overrun
);

  localparam logic [10:0] XMIN = SIDE_W;
  localparam logic [10:0] XMAX = H_DISP - SIDE_W - BLOCK_W;
  localparam logic [10:0] YMIN = SIDE_W;
  localparam logic [10:0] YMAX = V_DISP - SIDE_W - BLOCK_W;

  state_t state, state_nxt;
  logic [1:0]  idx, idx_nxt;
  logic        overrun_q;
  logic        pause_i;
  logic        start;

  logic [10:0]        pos_x [NUM_OBJ];
  logic [10:0]        pos_y [NUM_OBJ];
  logic [NUM_OBJ-1:0] dneg_x, dneg_y;
  logic [3:0]         spd_x [NUM_OBJ];
  logic [3:0]         spd_y [NUM_OBJ];
  logic [NUM_OBJ-1:0] en;

  logic [10:0] nx, ny;
  logic        ndx, ndy;

`ifdef MOTION_PAUSE_EN
  assign pause_i = pause;
`else
  assign pause_i = 1'b0;
`endif

  assign start = frame_start & ~pause_i;

  // FSM
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= ST_IDLE;
      idx   <= 2'd0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    busy        = 1'b0;
    update_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_UPD;
          idx_nxt   = 2'd0;
        end
      end
      ST_UPD: begin
        busy    = 1'b1;
        idx_nxt = idx + 2'd1;
        if (idx == 2'(NUM_OBJ - 1)) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy        = 1'b1;
        update_done = 1'b1;
        state_nxt   = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        idx_nxt   = 2'd0;
      end
    endcase
  end

  // frame_start during a sweep (including the DONE cycle) is dropped and flagged.
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) overrun_q <= 1'b0;
    else            overrun_q <= frame_start & busy;
  end

  assign overrun = overrun_q;

  // Config registers; a write to the object being stepped lands after the
  // step has already used the old speeds.
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      en <= 4'b0001;
      for (int i = 0; i < NUM_OBJ; i++) begin
        spd_x[i] <= 4'd1;
        spd_y[i] <= 4'd1;
      end
    end else if (cfg_we) begin
      en[cfg_addr]    <= cfg_wdata[8];
      spd_y[cfg_addr] <= cfg_wdata[7:4];
      spd_x[cfg_addr] <= cfg_wdata[3:0];
    end
  end

  // One stepper per axis, time-shared across objects through idx.
  axis_step u_step_x (
    .pos          (pos_x[idx]),
    .dir_neg      (dneg_x[idx]),
    .spd          (spd_x[idx]),
    .pos_min      (XMIN),
    .pos_max      (XMAX),
    .pos_next     (nx),
    .dir_neg_next (ndx)
  );

  axis_step u_step_y (
    .pos          (pos_y[idx]),
    .dir_neg      (dneg_y[idx]),
    .spd          (spd_y[idx]),
    .pos_min      (YMIN),
    .pos_max      (YMAX),
    .pos_next     (ny),
    .dir_neg_next (ndy)
  );

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      dneg_x <= '0;
      dneg_y <= '0;
      for (int i = 0; i < NUM_OBJ; i++) begin
        pos_x[i] <= init_x(SIDE_W, i);
        pos_y[i] <= YMIN;
      end
    end else if (state == ST_UPD && en[idx]) begin
      pos_x[idx]  <= nx;
      pos_y[idx]  <= ny;
      dneg_x[idx] <= ndx;
      dneg_y[idx] <= ndy;
    end
  end

  always_comb begin
    obj_x = '0;
    obj_y = '0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      obj_x[i*11 +: 11] = pos_x[i];
      obj_y[i*11 +: 11] = pos_y[i];
    end
  end

  assign obj_valid = en;

endmodule

// File: tb/tb_block_motion_sched.sv
module tb_block_motion_sched;

  logic        pixel_clk = 1'b0;
  logic        sys_rst_n;
  logic        frame_start;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [8:0]  cfg_wdata;
`ifdef MOTION_PAUSE_EN
  logic        pause;
`endif
  logic [43:0] obj_x;
  logic [43:0] obj_y;
  logic [3:0]  obj_valid;
  logic        busy;
  logic        update_done;
  logic        overrun;

  always #5 pixel_clk = ~pixel_clk;

  block_motion_sched dut (
    .pixel_clk   (pixel_clk),
    .sys_rst_n   (sys_rst_n),
    .frame_start (frame_start),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
`ifdef MOTION_PAUSE_EN
    .pause       (pause),
`endif
    .obj_x       (obj_x),
    .obj_y       (obj_y),
    .obj_valid   (obj_valid),
    .busy        (busy),
    .update_done (update_done),
    .overrun     (overrun)
  );

  typedef struct {
    logic        chk;
    logic [43:0] x;
    logic [43:0] y;
    logic [3:0]  v;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   n_done = 0;
  int   n_ovr  = 0;

  function automatic logic [43:0] pk(input logic [10:0] a, input logic [10:0] b,
                                     input logic [10:0] c, input logic [10:0] d);
    return {d, c, b, a};
  endfunction

  task automatic check(input string name, input logic [43:0] act, input logic [43:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: busy still high after cycle budget", name);
  endtask

  task automatic expect_sweep(input logic chk, input logic [43:0] x, input logic [43:0] y,
                              input logic [3:0] v);
    exp_t e;
    e.chk = chk;
    e.x   = x;
    e.y   = y;
    e.v   = v;
    sb_q.push_back(e);
  endtask

  // Monitor: every update_done pulse retires one scoreboard entry.
  always @(negedge pixel_clk) begin
    if (overrun === 1'b1) n_ovr++;
    if (update_done === 1'b1) begin
      n_done++;
      if (sb_q.size() == 0) begin
        check("unexpected_update_done", 44'd1, 44'd0);
      end else begin
        mon_e = sb_q.pop_front();
        if (mon_e.chk) begin
          check("sweep_obj_x", obj_x, mon_e.x);
          check("sweep_obj_y", obj_y, mon_e.y);
          check("sweep_obj_valid", 44'(obj_valid), 44'(mon_e.v));
        end
      end
    end
  end

  localparam logic [43:0] RX = {11'd280, 11'd200, 11'd120, 11'd40};
  localparam logic [43:0] RY = {11'd40, 11'd40, 11'd40, 11'd40};

  task automatic do_reset();
    sys_rst_n   = 1'b0;
    frame_start = 1'b0;
    cfg_we      = 1'b0;
    cfg_addr    = 2'd0;
    cfg_wdata   = 9'd0;
    repeat (2) @(negedge pixel_clk);
    sys_rst_n = 1'b1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_x"}, obj_x, RX);
    check({tag, "_y"}, obj_y, RY);
    check({tag, "_valid"}, 44'(obj_valid), 44'b0001);
    check({tag, "_busy"}, 44'(busy), 44'd0);
    check({tag, "_done"}, 44'(update_done), 44'd0);
    check({tag, "_overrun"}, 44'(overrun), 44'd0);
  endtask

  task automatic frame_pulse();
    @(negedge pixel_clk);
    frame_start = 1'b1;
    @(negedge pixel_clk);
    frame_start = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [8:0] d);
    @(negedge pixel_clk);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    @(negedge pixel_clk);
    cfg_we = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 20; k++) begin
      @(negedge pixel_clk);
      if (!busy) break;
    end
    if (k == 20) timeout(name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, o0, cnt;
    logic [10:0] ex;
`ifdef MOTION_PAUSE_EN
    pause = 1'b0;
`endif

    // Reset values and a single sweep with default configuration.
    do_reset();
    check_reset("reset");
    expect_sweep(1'b1, pk(41, 120, 200, 280), pk(41, 40, 40, 40), 4'b0001);
    d0 = n_done;
    frame_pulse();
    cnt = busy ? 1 : 0;
    @(negedge pixel_clk);
    check("t1_obj0_x_first_step", 44'(obj_x[10:0]), 44'd41);
    check("t1_obj0_y_first_step", 44'(obj_y[10:0]), 44'd41);
    if (busy) cnt++;
    for (int k = 0; k < 20; k++) begin
      @(negedge pixel_clk);
      if (busy) cnt++;
      else break;
    end
    check("t1_busy_cycles", 44'(cnt), 44'd5);
    check("t1_done_count", 44'(n_done - d0), 44'd1);
    check("t1_sb_empty", 44'(sb_q.size()), 44'd0);

    // Bounce on the X limits at 15 px/frame, then a stopped object on a limit.
    do_reset();
    cfg_write(2'd0, 9'h10F);
    for (int f = 1; f <= 156; f++) begin
      case (f)
        78:      begin ex = 11'd1200; expect_sweep(1'b1, pk(ex, 120, 200, 280), RY, 4'b0001); end
        79:      begin ex = 11'd1185; expect_sweep(1'b1, pk(ex, 120, 200, 280), RY, 4'b0001); end
        80:      begin ex = 11'd1170; expect_sweep(1'b1, pk(ex, 120, 200, 280), RY, 4'b0001); end
        155:     begin ex = 11'd45;   expect_sweep(1'b1, pk(ex, 120, 200, 280), RY, 4'b0001); end
        156:     begin ex = 11'd40;   expect_sweep(1'b1, pk(ex, 120, 200, 280), RY, 4'b0001); end
        default: expect_sweep(1'b0, '0, '0, '0);
      endcase
      frame_pulse();
      wait_idle("t2_sweep");
    end
    cfg_write(2'd0, 9'h100);
    expect_sweep(1'b1, pk(40, 120, 200, 280), RY, 4'b0001);
    frame_pulse();
    wait_idle("t2_zero_speed");
    cfg_write(2'd0, 9'h10F);
    expect_sweep(1'b1, pk(55, 120, 200, 280), RY, 4'b0001);
    frame_pulse();
    wait_idle("t2_after_min");
    check("t2_sb_empty", 44'(sb_q.size()), 44'd0);

    // frame_start during a sweep.
    do_reset();
    d0 = n_done;
    o0 = n_ovr;
    expect_sweep(1'b1, pk(41, 120, 200, 280), pk(41, 40, 40, 40), 4'b0001);
    frame_pulse();
    @(negedge pixel_clk);
    frame_start = 1'b1;
    @(negedge pixel_clk);
    frame_start = 1'b0;
    wait_idle("t3_sweep");
    repeat (10) @(negedge pixel_clk);
    check("t3_overrun_count", 44'(n_ovr - o0), 44'd1);
    check("t3_done_count", 44'(n_done - d0), 44'd1);
    check("t3_obj0_x_one_step", 44'(obj_x[10:0]), 44'd41);
    check("t3_sb_empty", 44'(sb_q.size()), 44'd0);

    // Enabling obj2.
    do_reset();
    cfg_write(2'd2, 9'h111);
    expect_sweep(1'b1, pk(41, 120, 201, 280), pk(41, 40, 41, 40), 4'b0101);
    frame_pulse();
    wait_idle("t4_sweep");
    check("t4_sb_empty", 44'(sb_q.size()), 44'd0);

    // Reset in the middle of a sweep (UPD, idx 2).
    do_reset();
    d0 = n_done;
    frame_pulse();
    repeat (2) @(negedge pixel_clk);
    check("t5_busy_mid_sweep", 44'(busy), 44'd1);
    sys_rst_n = 1'b0;
    #1;
    check_reset("t5_async");
    repeat (3) @(negedge pixel_clk);
    sys_rst_n = 1'b1;
    repeat (10) @(negedge pixel_clk);
    check("t5_no_done", 44'(n_done - d0), 44'd0);
    check_reset("t5_after");

    // Config write to the object being stepped applies from the next frame.
    do_reset();
    expect_sweep(1'b1, pk(41, 120, 200, 280), pk(41, 40, 40, 40), 4'b0001);
    frame_pulse();
    cfg_we    = 1'b1;
    cfg_addr  = 2'd0;
    cfg_wdata = 9'h1FF;
    @(negedge pixel_clk);
    cfg_we = 1'b0;
    wait_idle("t6_sweep1");
    expect_sweep(1'b1, pk(56, 120, 200, 280), pk(56, 40, 40, 40), 4'b0001);
    frame_pulse();
    wait_idle("t6_sweep2");
    check("t6_sb_empty", 44'(sb_q.size()), 44'd0);

`ifdef MOTION_PAUSE_EN
    // Pause suppresses sweeps entirely.
    do_reset();
    d0 = n_done;
    o0 = n_ovr;
    pause = 1'b1;
    for (int p = 0; p < 3; p++) begin
      frame_pulse();
      repeat (8) @(negedge pixel_clk);
    end
    pause = 1'b0;
    check("t7_no_done", 44'(n_done - d0), 44'd0);
    check("t7_no_overrun", 44'(n_ovr - o0), 44'd0);
    check("t7_x_held", obj_x, RX);
    check("t7_y_held", obj_y, RY);
`endif

    check("final_sb_empty", 44'(sb_q.size()), 44'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
